// File: rtl/ascon_fsm.sv
// ascon_fsm: control sequencer for a one-round-per-cycle ASCON-128 encryption
// datapath. Sequences init (p^12), AD absorption (p^6 per block), plaintext
// encryption (p^6 per non-final block) and finalisation (p^12 + key XORs).
// Carries control only; block data flows directly into the datapath.
// Optional feature: define ASCON_ABORT_EN to add abort_i, which returns a
// running operation to IDLE on the next edge with all enables held low.
module ascon_fsm (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       ad_en_i,
  input  logic       block_valid_i,
  input  logic       block_last_i,
`ifdef ASCON_ABORT_EN
  input  logic       abort_i,
`endif
  output logic       block_ready_o,
  output logic       select_o,
  output logic [3:0] round_o,
  output logic       en_state_o,
  output logic       en_xor_data_o,
  output logic       en_xor_begin_key_o,
  output logic       en_xor_lsb_o,
  output logic       en_xor_end_key_o,
  output logic       en_out_cipher_o,
  output logic       en_out_tag_o,
  output logic       cipher_valid_o,
  output logic       tag_valid_o,
  output logic       busy_o
);

  typedef enum logic [2:0] {
    IDLE, INIT, AD_WAIT, AD_PERM, PT_WAIT, PT_PERM, FINAL, TAG
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       ad_flag_q, ad_flag_d;
  logic       last_q, last_d;
  logic       cipher_valid_q, tag_valid_q;
  logic       abort_hit;

`ifdef ASCON_ABORT_EN
  assign abort_hit = abort_i && (state_q != IDLE);
`else
  assign abort_hit = 1'b0;
`endif

  assign cipher_valid_o = cipher_valid_q;
  assign tag_valid_o    = tag_valid_q;

  // State register, round counter, latched flags and the registered valid pulses
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= IDLE;
      rnd_q          <= 4'd0;
      ad_flag_q      <= 1'b0;
      last_q         <= 1'b0;
      cipher_valid_q <= 1'b0;
      tag_valid_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      rnd_q          <= rnd_d;
      ad_flag_q      <= ad_flag_d;
      last_q         <= last_d;
      cipher_valid_q <= en_out_cipher_o;
      tag_valid_q    <= en_out_tag_o;
    end
  end

  // Next-state and round-counter sequencing
  always_comb begin
    state_d   = state_q;
    rnd_d     = rnd_q;
    ad_flag_d = ad_flag_q;
    last_d    = last_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = INIT;
          rnd_d     = 4'd0;
          ad_flag_d = ad_en_i;
        end
      end
      INIT: begin
        if (rnd_q == 4'd11) begin
          state_d = ad_flag_q ? AD_WAIT : PT_WAIT;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      AD_WAIT: begin
        if (block_valid_i) begin
          state_d = AD_PERM;
          rnd_d   = 4'd7;
          last_d  = block_last_i;
        end
      end
      AD_PERM: begin
        if (rnd_q == 4'd11) begin
          state_d = last_q ? PT_WAIT : AD_WAIT;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      PT_WAIT: begin
        if (block_valid_i) begin
          // The last plaintext block starts the p^12 finalisation at round 0
          state_d = block_last_i ? FINAL : PT_PERM;
          rnd_d   = block_last_i ? 4'd1 : 4'd7;
        end
      end
      PT_PERM: begin
        if (rnd_q == 4'd11) begin
          state_d = PT_WAIT;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      FINAL: begin
        if (rnd_q == 4'd11) begin
          state_d = TAG;
          rnd_d   = 4'd0;
        end else begin
          rnd_d = rnd_q + 4'd1;
        end
      end
      TAG: begin
        state_d = IDLE;
        rnd_d   = 4'd0;
      end
      default: begin
        state_d = IDLE;
        rnd_d   = 4'd0;
      end
    endcase
    if (abort_hit) begin
      state_d = IDLE;
      rnd_d   = 4'd0;
    end
  end

  // Datapath controls; WAIT-state controls follow block_valid_i/block_last_i
  always_comb begin
    block_ready_o      = 1'b0;
    select_o           = 1'b1;
    round_o            = 4'd0;
    en_state_o         = 1'b0;
    en_xor_data_o      = 1'b0;
    en_xor_begin_key_o = 1'b0;
    en_xor_lsb_o       = 1'b0;
    en_xor_end_key_o   = 1'b0;
    en_out_cipher_o    = 1'b0;
    en_out_tag_o       = 1'b0;
    busy_o             = (state_q != IDLE);
    if (!abort_hit) begin
      case (state_q)
        INIT: begin
          en_state_o = 1'b1;
          round_o    = rnd_q;
          select_o   = (rnd_q != 4'd0);
          if (rnd_q == 4'd11) begin
            en_xor_end_key_o = 1'b1;
            en_xor_lsb_o     = !ad_flag_q;
          end
        end
        AD_WAIT: begin
          block_ready_o = 1'b1;
          if (block_valid_i) begin
            round_o       = 4'd6;
            en_xor_data_o = 1'b1;
            en_state_o    = 1'b1;
          end
        end
        AD_PERM: begin
          en_state_o = 1'b1;
          round_o    = rnd_q;
          if (rnd_q == 4'd11) en_xor_lsb_o = last_q;
        end
        PT_WAIT: begin
          block_ready_o = 1'b1;
          if (block_valid_i) begin
            en_state_o      = 1'b1;
            en_xor_data_o   = 1'b1;
            en_out_cipher_o = 1'b1;
            if (block_last_i) begin
              round_o            = 4'd0;
              en_xor_begin_key_o = 1'b1;
            end else begin
              round_o = 4'd6;
            end
          end
        end
        PT_PERM: begin
          en_state_o = 1'b1;
          round_o    = rnd_q;
        end
        FINAL: begin
          en_state_o = 1'b1;
          round_o    = rnd_q;
          if (rnd_q == 4'd11) en_xor_end_key_o = 1'b1;
        end
        TAG: begin
          en_out_tag_o = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
